// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin two-master Wishbone arbiter in front of main_memory,
// one single-beat transfer per grant, with a watchdog that aborts unacked transfers.
module wb_mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_m0_cyc,
    input  logic                  i_m0_stb,
    input  logic                  i_m0_we,
    input  logic [ADDR_W-1:0]     i_m0_addr,
    input  logic [DATA_W-1:0]     i_m0_data,
    input  logic [DATA_W/8-1:0]   i_m0_sel,
    output logic                  o_m0_ack,
    output logic                  o_m0_err,
    output logic                  o_m0_stall,
    output logic [DATA_W-1:0]     o_m0_data,
    input  logic                  i_m1_cyc,
    input  logic                  i_m1_stb,
    input  logic                  i_m1_we,
    input  logic [ADDR_W-1:0]     i_m1_addr,
    input  logic [DATA_W-1:0]     i_m1_data,
    input  logic [DATA_W/8-1:0]   i_m1_sel,
    output logic                  o_m1_ack,
    output logic                  o_m1_err,
    output logic                  o_m1_stall,
    output logic [DATA_W-1:0]     o_m1_data,
    output logic                  o_s_cyc,
    output logic                  o_s_stb,
    output logic                  o_s_we,
    output logic [ADDR_W-1:0]     o_s_addr,
    output logic [DATA_W-1:0]     o_s_data,
    output logic [DATA_W/8-1:0]   o_s_sel,
    input  logic                  i_s_ack,
    input  logic                  i_s_stall,
    input  logic [DATA_W-1:0]     i_s_data,
    output logic [1:0]            o_grant
);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t          state, state_nx;
    logic            last;
    logic [WW-1:0]   wdog;
    logic            req0, req1, own0, own1, cyc, kill, done;

    assign req0 = i_m0_cyc & i_m0_stb;
    assign req1 = i_m1_cyc & i_m1_stb;
    assign own0 = state == GNT0;
    assign own1 = state == GNT1;
    assign cyc  = own0 ? i_m0_cyc : own1 ? i_m1_cyc : 1'b0;
    // ack in the last watchdog cycle still completes the transfer normally
    assign kill = cyc & ~i_s_ack & (wdog == WDOG_MAX);
    assign done = ~cyc | i_s_ack | kill;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            wdog  <= '0;
        end else begin
            state <= state_nx;
            if (state != IDLE && done)
                last <= own1;
            wdog  <= (state != IDLE && !done) ? wdog + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = (req0 & (~req1 | last)) ? GNT0 : req1 ? GNT1 : IDLE;
        else if (done)
            state_nx = IDLE;
    end

    always_comb begin
        o_s_cyc    = cyc & ~kill;
        o_s_stb    = o_s_cyc & (own0 ? i_m0_stb : own1 ? i_m1_stb : 1'b0);
        o_s_we     = own0 ? i_m0_we   : own1 ? i_m1_we   : 1'b0;
        o_s_addr   = own0 ? i_m0_addr : own1 ? i_m1_addr : '0;
        o_s_data   = own0 ? i_m0_data : own1 ? i_m1_data : '0;
        o_s_sel    = own0 ? i_m0_sel  : own1 ? i_m1_sel  : '0;
        o_m0_ack   = own0 & cyc & i_s_ack;
        o_m1_ack   = own1 & cyc & i_s_ack;
        o_m0_err   = own0 & kill;
        o_m1_err   = own1 & kill;
        o_m0_stall = own0 ? i_s_stall : 1'b1;
        o_m1_stall = own1 ? i_s_stall : 1'b1;
        o_m0_data  = i_s_data;
        o_m1_data  = i_s_data;
        o_grant    = {own1, own0};
    end
endmodule
